// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int WORD_SIZE = 16;

   typedef logic [WORD_SIZE-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 16'h0000;

   // Fetch control states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SKID    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

   // One fetched instruction together with its address and predicted successor.
   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t pred_pc;
   } fetch_entry_t;

   // A memory read is outstanding in these states.
   function automatic logic req_active(input fetch_state_t s);
      return (s == ST_REQ) || (s == ST_DISCARD);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: predictor, instruction memory, redirect/stall and IF/ID outputs.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   word_t       pc;
   word_t       pred_next_pc;
   logic        redirect;
   word_t       redirect_pc;
   logic        stall;
   logic        i_req;
   logic        i_ack;
   word_t       i_data;
   logic        if_valid;
   word_t       if_instr;
   word_t       if_pc;
   word_t       if_pred_pc;
   logic [15:0] fetch_count;

   // Fetch unit side.
   modport master (
      output pc, i_req, if_valid, if_instr, if_pc, if_pred_pc, fetch_count,
      input  pred_next_pc, redirect, redirect_pc, stall, i_ack, i_data
   );

   // Pipeline/memory environment side.
   modport slave (
      input  pc, i_req, if_valid, if_instr, if_pc, if_pred_pc, fetch_count,
      output pred_next_pc, redirect, redirect_pc, stall, i_ack, i_data
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched instruction while decode is stalled.
module fetch_skid_buf
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output logic         valid_o,
   output fetch_entry_t entry_o
);

   logic         valid_q;
   fetch_entry_t entry_q;

   // Entry register: clear wins over load, load wins over drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         // NOTE: the payload is reset as well so it never shows X downstream, even though valid_q alone qualifies it.
         entry_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
         if (clear_i) begin
            valid_q <= 1'b0;
         end else if (load_i) begin
            valid_q <= 1'b1;
            entry_q <= entry_i;
         end else if (drain_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid_o = valid_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, memory handshake, IF/ID latch, redirect and stall handling.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   fetch_unit_if.master bus
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pending_q, pending_d;
   fetch_entry_t ifid_q, ifid_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [15:0]  count_q, count_d;

   logic         skid_load, skid_drain, skid_clear;
   logic         skid_valid;
   fetch_entry_t skid_entry;
   fetch_entry_t fetched;

   assign fetched = '{instr: bus.i_data, pc: pc_q, pred_pc: bus.pred_next_pc};

   fetch_skid_buf u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (skid_clear),
      .entry_i (fetched),
      .valid_o (skid_valid),
      .entry_o (skid_entry)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         pending_q    <= '0;
         ifid_q       <= '0;
         ifid_valid_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         ifid_q       <= ifid_d;
         ifid_valid_q <= ifid_valid_d;
         count_q      <= count_d;
      end
   end

   // Next-state logic: redirect beats ack and stall; an issued request is never withdrawn.
   always_comb begin
      // NOTE: every next-state value is defaulted first so no path through the case infers a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      pending_d    = pending_q;
      ifid_d       = ifid_q;
      ifid_valid_d = ifid_valid_q;
      count_d      = count_q;
      skid_load    = 1'b0;
      skid_drain   = 1'b0;
      skid_clear   = bus.redirect;

      // Decode consumes the IF/ID entry whenever it is not stalled.
      if (!bus.stall) ifid_valid_d = 1'b0;
      if (bus.redirect) ifid_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (bus.redirect) pc_d = bus.redirect_pc;
         end

         ST_REQ: begin
            if (bus.redirect) begin
               if (bus.i_ack) begin
                  pc_d = bus.redirect_pc;
               end else begin
                  // Request still outstanding: finish it, then jump.
                  pending_d = bus.redirect_pc;
                  state_d   = ST_DISCARD;
               end
            end else if (bus.i_ack) begin
               pc_d = bus.pred_next_pc;
               if (!bus.stall) begin
                  ifid_d       = fetched;
                  ifid_valid_d = 1'b1;
                  count_d      = count_q + 16'd1;
               end else begin
                  skid_load = 1'b1;
                  state_d   = ST_SKID;
               end
            end
         end

         ST_SKID: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_pc;
               state_d = ST_REQ;
            end else if (!bus.stall) begin
               skid_drain = 1'b1;
               state_d    = ST_REQ;
               if (skid_valid) begin
                  ifid_d       = skid_entry;
                  ifid_valid_d = 1'b1;
                  count_d      = count_q + 16'd1;
               end
            end
         end

         ST_DISCARD: begin
            if (bus.redirect) begin
               if (bus.i_ack) begin
                  pc_d    = bus.redirect_pc;
                  state_d = ST_REQ;
               end else begin
                  pending_d = bus.redirect_pc;
               end
            end else if (bus.i_ack) begin
               pc_d    = pending_q;
               state_d = ST_REQ;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.i_req       = req_active(state_q);
   assign bus.if_valid    = ifid_valid_q;
   assign bus.if_instr    = ifid_q.instr;
   assign bus.if_pc       = ifid_q.pc;
   assign bus.if_pred_pc  = ifid_q.pred_pc;
   assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage placed directly upstream of the branch predictor and the IF/ID latch. It holds the architectural fetch PC, presents it to the predictor and instruction memory, and advances it to the predictor's `next_PC`. On a misprediction it redirects to the resolved target and squashes anything in flight. It also absorbs decode-side stalls with a one-entry skid buffer so the memory handshake is never broken.

## Interface
- `WORD_SIZE`, 16, instruction/address width
- `RESET_PC`, 16'h0000, fetch PC after reset
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  reset; one clock, reset asynchronous and active-low
- `pc`  out  WORD_SIZE  current fetch PC, to predictor `PC` and memory address
- `pred_next_pc`  in  WORD_SIZE  predictor `next_PC` for `pc`
- `redirect`  in  1  misprediction flush (branch_signal)
- `redirect_pc`  in  WORD_SIZE  resolved correct PC
- `stall`  in  1  ID hazard stall (e.g. branch_stall); IF/ID must hold
- `i_req`  out  1  instruction read request
- `i_ack`  in  1  read complete; `i_data` valid this cycle
- `i_data`  in  WORD_SIZE  fetched instruction
- `if_valid`  out  1  IF/ID holds a live instruction
- `if_instr`  out  WORD_SIZE  IF/ID instruction
- `if_pc`  out  WORD_SIZE  PC of `if_instr`
- `if_pred_pc`  out  WORD_SIZE  predicted next PC carried to resolve
- `fetch_count`  out  16  instructions accepted into IF/ID

## Operation
- FSM states: IDLE, REQ, SKID, DISCARD.
- IDLE: entered only by reset; next edge -> REQ.
- REQ: `i_req`=1, `pc` stable. On `i_ack`: if `stall`=0, load IF/ID {`i_data`,`pc`,`pred_next_pc`}, `if_valid`<=1, `pc`<=`pred_next_pc`, stay REQ. If `stall`=1, write skid entry, `pc`<=`pred_next_pc`, -> SKID.
- SKID: `i_req`=0. When `stall` falls, skid -> IF/ID, -> REQ.
- Stall with no ack: IF/ID holds; outstanding request continues (handshake never withdrawn).
- `if_valid` drops to 0 when ID consumes (`stall`=0) and no new instruction arrives.
- Redirect (priority over stall and ack): next edge `if_valid`<=0, skid cleared. If `i_ack`=1 same cycle or state is SKID/IDLE: drop data, `pc`<=`redirect_pc`, -> REQ. If REQ with no ack: latch `redirect_pc` into pending register, -> DISCARD.
- DISCARD: `i_req`=1 at old `pc`; on `i_ack` drop data, `pc`<=pending, -> REQ. A further redirect in DISCARD overwrites pending.
- `fetch_count` +1 per instruction written to IF/ID (direct or from skid); wraps 16'hFFFF -> 0; not incremented for dropped data.

## Timing
- Reset values: `pc`=RESET_PC, `i_req`=0, `if_valid`=0, `if_instr`/`if_pc`/`if_pred_pc`=0, `fetch_count`=0, state IDLE, skid empty.
- Reset mid-transaction: all state cleared immediately; pending ack ignored.
- `i_req` first high in the cycle after the first rising edge with `reset_n`=1.
- Zero-wait memory (`i_ack` same cycle as `i_req`) gives one instruction per cycle; latency fetch-to-IF/ID = 1 edge.
- `pc` changes only on an ack edge or a redirect edge where no request is outstanding.
- `redirect` sampled at the edge; flush visible on `if_valid` the following cycle.

## Structure
- `WORD_SIZE` and opcode constants from shared `opcodes.v`; FSM state encodings as localparams in the same header.
- One natural sub-module: `fetch_skid_buf` (one-entry {instr, pc, pred_pc} register with valid, load, drain, clear).

## Test plan
- Reset release, zero-wait memory, predictor `pc+1`: `pc` 0,1,2,3; `if_pc` follows one cycle later; `fetch_count`=3 after 3 acks.
- Predictor target: at `pc`=4, `pred_next_pc`=0x20 -> next `pc`=0x20, `if_pred_pc`=0x20 with `if_pc`=4.
- Stall 3 cycles with ack during stall: IF/ID holds, state SKID, `i_req`=0; stall release -> skid instr in IF/ID next cycle, count +1.
- Redirect to 0x40 while request outstanding (ack delayed 2 cycles): DISCARD, old data dropped, next `pc`=0x40, count unchanged.
- Redirect coinciding with stall and ack: `if_valid`=0 next cycle, skid empty, `pc`=`redirect_pc`.
- `reset_n` pulse mid-REQ and `fetch_count` preset to 0xFFFF: counter wraps to 0; reset returns all outputs to reset values.
